// File: rtl/fir_tap_arbiter_pkg.sv
// Shared types and constants for the tap coefficient BRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  // Config-read sequencing through the single-port BRAM
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_HOLD = 2'd2
  } fsm_state_t;

  // Which requester owns the BRAM port this cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WR   = 2'd1,
    SEL_RD   = 2'd2,
    SEL_ENG  = 2'd3
  } req_sel_t;

  // Tap region lives at AXI-Lite 0x080-0x0FF; the low 7 bits are the BRAM byte offset
  localparam logic [11:0] TAP_BASE = 12'h080;
  localparam logic [11:0] TAP_MASK = 12'h07F;

endpackage

// File: rtl/fir_tap_arbiter_prio_sel.sv
// Fixed/forced priority selector for the tap BRAM port; one-hot grant {eng, rd, wr}.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: losers get no grant and are expected to hold their request.
//
// Ports: wr_req/rd_req/eng_req are already-eligible requests, busy selects the
// run-time priority order, force_rd lets a starved config read beat the engine.
module fir_tap_prio_sel
  import fir_pkg::*;
(
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       eng_req,
  input  logic       busy,
  input  logic       force_rd,
  output logic [2:0] gnt_oh,
  output req_sel_t   sel
);

  always_comb begin
    sel = SEL_NONE;
    if (!busy) begin
      if (wr_req)       sel = SEL_WR;
      else if (rd_req)  sel = SEL_RD;
      else if (eng_req) sel = SEL_ENG;
    end else begin
      // Config writes never win during a run; they simply stay pending.
      if (force_rd && rd_req) sel = SEL_RD;
      else if (eng_req)       sel = SEL_ENG;
      else if (rd_req)        sel = SEL_RD;
    end
    gnt_oh = {sel == SEL_ENG, sel == SEL_RD, sel == SEL_WR};
  end

endmodule

// File: rtl/fir_tap_arbiter.sv
// Arbitrates the single-port tap BRAM between config write, config read and engine fetch.
// Latency: grants/BRAM controls combinational; engine data 1 cycle, config read data 2 cycles after grant.
// Backpressure: denied requesters hold req; read data held in cfg_rd_valid until cfg_rd_ready.
//
// Ports: axis_clk/axis_rst (sync, active-high); ap_busy; cfg_wr_* and cfg_rd_*
// request/grant from AXI-Lite decode; eng_* engine fetch port; taps_loaded;
// tap_WE/EN/Di/A/Do to the BRAM.
// Optional: define FIR_TAP_STARVE_GUARD_EN to force a config read through after
// pStarveMax denied cycles during a run.
module fir_tap_arbiter
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pStarveMax  = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_busy,
  input  logic                   cfg_wr_req,
  input  logic [pADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [pDATA_WIDTH-1:0] cfg_wr_data,
  output logic                   cfg_wr_gnt,
  input  logic                   cfg_rd_req,
  input  logic [pADDR_WIDTH-1:0] cfg_rd_addr,
  output logic                   cfg_rd_gnt,
  output logic                   cfg_rd_valid,
  input  logic                   cfg_rd_ready,
  output logic [pDATA_WIDTH-1:0] cfg_rd_data,
  input  logic                   eng_req,
  input  logic [3:0]             eng_idx,
  output logic                   eng_gnt,
  output logic                   eng_valid,
  output logic [pDATA_WIDTH-1:0] eng_data,
  output logic                   taps_loaded,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  localparam logic [pADDR_WIDTH-1:0] OFF_MASK  = pADDR_WIDTH'(TAP_MASK);
  localparam logic [pADDR_WIDTH-1:0] OFF_LIMIT = pADDR_WIDTH'(4 * Tape_Num);

  fsm_state_t            state;
  req_sel_t              sel;
  logic [2:0]            gnt_oh;
  logic                  force_rd;
  logic                  rd_oor;
  logic [Tape_Num-1:0]   loaded;
  logic [Tape_Num-1:0]   set_vec;

  logic [pADDR_WIDTH-1:0] wr_off, rd_off;
  logic                   wr_in_range, rd_in_range;
  logic                   wr_elig, rd_elig, eng_elig;

  assign wr_off      = cfg_wr_addr & OFF_MASK;
  assign rd_off      = cfg_rd_addr & OFF_MASK;
  assign wr_in_range = wr_off < OFF_LIMIT;
  assign rd_in_range = rd_off < OFF_LIMIT;

  // Nothing is granted while reset is asserted; a new config read only starts from idle.
  assign wr_elig  = cfg_wr_req && !axis_rst;
  assign rd_elig  = cfg_rd_req && !axis_rst && (state == ST_IDLE);
  assign eng_elig = eng_req && !axis_rst;

  fir_tap_prio_sel u_prio_sel (
    .wr_req   (wr_elig),
    .rd_req   (rd_elig),
    .eng_req  (eng_elig),
    .busy     (ap_busy),
    .force_rd (force_rd),
    .gnt_oh   (gnt_oh),
    .sel      (sel)
  );

  assign {eng_gnt, cfg_rd_gnt, cfg_wr_gnt} = gnt_oh;

`ifdef FIR_TAP_STARVE_GUARD_EN
  localparam int             SW         = $clog2(pStarveMax + 1);
  localparam logic [SW-1:0]  STARVE_LIM = SW'(pStarveMax);
  logic [SW-1:0] starve_cnt;

  assign force_rd = (starve_cnt == STARVE_LIM);

  // Counts run cycles in which a pending config read lost to the engine; saturates at the limit.
  always_ff @(posedge axis_clk) begin
    if (axis_rst)                                                starve_cnt <= '0;
    else if (cfg_rd_gnt)                                         starve_cnt <= '0;
    else if (ap_busy && rd_elig && (starve_cnt != STARVE_LIM))   starve_cnt <= starve_cnt + 1'b1;
  end
`else
  // Strict engine priority; pStarveMax has no effect in this build.
  assign force_rd = (pStarveMax < 0);
`endif

  // BRAM port driven straight from the grant; out-of-range config accesses never touch it.
  always_comb begin
    tap_WE = 4'h0;
    tap_EN = 1'b0;
    tap_Di = '0;
    tap_A  = '0;
    case (sel)
      SEL_WR: if (wr_in_range) begin
        tap_WE = 4'hF;
        tap_EN = 1'b1;
        tap_Di = cfg_wr_data;
        tap_A  = wr_off;
      end
      SEL_RD: if (rd_in_range) begin
        tap_EN = 1'b1;
        tap_A  = rd_off;
      end
      SEL_ENG: begin
        tap_EN = 1'b1;
        tap_A  = pADDR_WIDTH'({eng_idx, 2'b00});
      end
      default: ;
    endcase
  end

  // Loaded-mask bit for the tap being written this cycle (in-range writes only)
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < Tape_Num; i++) begin
      set_vec[i] = cfg_wr_gnt && wr_in_range &&
                   (wr_off[pADDR_WIDTH-1:2] == (pADDR_WIDTH-2)'(i));
    end
  end

  // The BRAM output register is the engine pipeline stage, so data is qualified, not re-registered.
  assign eng_data = eng_valid ? tap_Do : '0;

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state        <= ST_IDLE;
      cfg_rd_valid <= 1'b0;
      cfg_rd_data  <= '0;
      rd_oor       <= 1'b0;
      eng_valid    <= 1'b0;
      loaded       <= '0;
      taps_loaded  <= 1'b0;
    end else begin
      eng_valid   <= eng_gnt;
      loaded      <= loaded | set_vec;
      // Include this cycle's write so taps_loaded rises right after the last tap lands.
      taps_loaded <= &(loaded | set_vec);
      case (state)
        ST_IDLE: if (cfg_rd_gnt) begin
          state  <= ST_RD_WAIT;
          rd_oor <= !rd_in_range;
        end
        ST_RD_WAIT: begin
          cfg_rd_data  <= rd_oor ? '0 : tap_Do;
          cfg_rd_valid <= 1'b1;
          state        <= ST_RD_HOLD;
        end
        ST_RD_HOLD: if (cfg_rd_ready) begin
          cfg_rd_valid <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_arbiter.sv
module tb_fir_tap_arbiter;
  import fir_pkg::*;

`ifdef FIR_TAP_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int STARVE_MAX = 8;
  localparam logic [11:0] LIMIT = 12'd44;

  logic        axis_clk, axis_rst, ap_busy;
  logic        cfg_wr_req, cfg_wr_gnt;
  logic [11:0] cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic        cfg_rd_req, cfg_rd_gnt, cfg_rd_valid, cfg_rd_ready;
  logic [11:0] cfg_rd_addr;
  logic [31:0] cfg_rd_data;
  logic        eng_req, eng_gnt, eng_valid;
  logic [3:0]  eng_idx;
  logic [31:0] eng_data;
  logic        taps_loaded;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [31:0] tap_Di, tap_Do;
  logic [11:0] tap_A;

  fir_tap_arbiter dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .ap_busy(ap_busy),
    .cfg_wr_req(cfg_wr_req), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
    .cfg_wr_gnt(cfg_wr_gnt), .cfg_rd_req(cfg_rd_req), .cfg_rd_addr(cfg_rd_addr),
    .cfg_rd_gnt(cfg_rd_gnt), .cfg_rd_valid(cfg_rd_valid), .cfg_rd_ready(cfg_rd_ready),
    .cfg_rd_data(cfg_rd_data), .eng_req(eng_req), .eng_idx(eng_idx), .eng_gnt(eng_gnt),
    .eng_valid(eng_valid), .eng_data(eng_data), .taps_loaded(taps_loaded),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // Tap BRAM: 32 words, one-cycle read latency, preloaded with a recognisable pattern
  logic [31:0] mem [0:31];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + i;
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[6:2]] <= tap_Di;
      tap_Do <= mem[tap_A[6:2]];
    end
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_tot++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] ref_coef [0:31];
  initial for (int i = 0; i < 32; i++) ref_coef[i] = 32'hC0DE_0000 + i;
  bit [10:0]   m_loaded = '0;
  int          m_stage = 0;      // 0 no read, 1 waiting on BRAM, 2 presenting data
  logic [31:0] m_rd_val = '0;
  int          m_starve = 0;
  bit          mdl_on = 1'b0;
  logic        exp_rd_valid = 1'b0, exp_eng_valid = 1'b0, exp_loaded = 1'b0;
  logic [31:0] exp_rd_data = '0, exp_eng_data = '0;

  always @(negedge axis_clk) begin : cmp
    int w;   // 0 none, 1 write, 2 read, 3 engine
    bit rd_ok, e_en;
    logic [3:0]  e_we;
    logic [11:0] woff, roff, e_a;
    logic [31:0] e_di;
    if (mdl_on) begin
      rd_ok = cfg_rd_req && (m_stage == 0);
      woff  = cfg_wr_addr & TAP_MASK;
      roff  = cfg_rd_addr & TAP_MASK;
      if (axis_rst)                                        w = 0;
      else if (!ap_busy)                                   w = cfg_wr_req ? 1 : rd_ok ? 2 : eng_req ? 3 : 0;
      else if (GUARD && rd_ok && m_starve >= STARVE_MAX)   w = 2;
      else                                                 w = eng_req ? 3 : rd_ok ? 2 : 0;
      e_en = 1'b0; e_we = 4'h0; e_a = '0; e_di = '0;
      if (w == 1 && woff < LIMIT) begin e_en = 1'b1; e_we = 4'hF; e_a = woff; e_di = cfg_wr_data; end
      if (w == 2 && roff < LIMIT) begin e_en = 1'b1; e_a = roff; end
      if (w == 3) begin e_en = 1'b1; e_a = {6'd0, eng_idx, 2'b00}; end
      chk("wr_gnt", cfg_wr_gnt, w == 1);
      chk("rd_gnt", cfg_rd_gnt, w == 2);
      chk("eng_gnt", eng_gnt, w == 3);
      chk("tap_EN", tap_EN, e_en);
      chk("tap_WE", tap_WE, e_we);
      if (e_en) chk("tap_A", tap_A, e_a);
      if (e_we != 0) chk("tap_Di", tap_Di, e_di);
      chk("rd_valid", cfg_rd_valid, exp_rd_valid);
      if (exp_rd_valid) chk("rd_data", cfg_rd_data, exp_rd_data);
      chk("eng_valid", eng_valid, exp_eng_valid);
      if (exp_eng_valid) chk("eng_data", eng_data, exp_eng_data);
      chk("taps_loaded", taps_loaded, exp_loaded);
      // next-cycle expectations
      if (axis_rst) begin
        m_loaded = '0; m_stage = 0; m_starve = 0;
        exp_rd_valid = 1'b0; exp_rd_data = '0; exp_eng_valid = 1'b0; exp_loaded = 1'b0;
      end else begin
        exp_eng_valid = (w == 3);
        if (w == 3) exp_eng_data = ref_coef[eng_idx];
        if (w == 1 && woff < LIMIT) begin
          ref_coef[woff[6:2]] = cfg_wr_data;
          m_loaded[woff[5:2]] = 1'b1;
        end
        exp_loaded = &m_loaded;
        if (m_stage == 2) begin
          if (cfg_rd_ready) begin m_stage = 0; exp_rd_valid = 1'b0; end
        end else if (m_stage == 1) begin
          m_stage = 2; exp_rd_valid = 1'b1; exp_rd_data = m_rd_val;
        end
        if (w == 2) begin
          m_stage  = 1;
          m_rd_val = (roff < LIMIT) ? ref_coef[roff[6:2]] : 32'd0;
          m_starve = 0;
        end else if (ap_busy && rd_ok) m_starve++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge axis_clk); #1;
  endtask

  task automatic do_wr(input logic [11:0] a, input logic [31:0] d, output bit en_at_gnt);
    bit got = 1'b0;
    cfg_wr_req = 1'b1; cfg_wr_addr = a; cfg_wr_data = d; en_at_gnt = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge axis_clk);
      if (cfg_wr_gnt) begin got = 1'b1; en_at_gnt = tap_EN; end
    end
    chk("wr_grant_seen", got, 1);
    tick();
    cfg_wr_req = 1'b0;
  endtask

  task automatic wait_rd_gnt();
    bit got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge axis_clk);
      if (cfg_rd_gnt) got = 1'b1;
    end
    chk("rd_grant_seen", got, 1);
    tick();
    cfg_rd_req = 1'b0;
  endtask

  task automatic wait_rd_valid(output logic [31:0] d);
    bit seen = 1'b0;
    d = 'x;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge axis_clk);
      if (cfg_rd_valid) begin seen = 1'b1; d = cfg_rd_data; end
    end
    chk("rd_valid_seen", seen, 1);
    tick();
  endtask

  task automatic do_rd(input logic [11:0] a, output logic [31:0] d);
    cfg_rd_req = 1'b1; cfg_rd_addr = a;
    wait_rd_gnt();
    cfg_rd_ready = 1'b1;
    wait_rd_valid(d);
    cfg_rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit en;
    int cnt, wcnt, ecnt, first;
    logic [31:0] d;
    axis_rst = 1'b1; ap_busy = 1'b0;
    cfg_wr_req = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    cfg_rd_req = 1'b0; cfg_rd_addr = '0; cfg_rd_ready = 1'b0;
    eng_req = 1'b0; eng_idx = '0;
    tick();
    mdl_on = 1'b1;
    tick();
    @(negedge axis_clk);
    chk("rst_rd_valid", cfg_rd_valid, 0);
    chk("rst_taps_loaded", taps_loaded, 0);
    chk("rst_eng_valid", eng_valid, 0);
    chk("rst_tap_EN", tap_EN, 0);
    tick();
    axis_rst = 1'b0;

    // Load taps 0..10 with their index
    wcnt = 0;
    for (int i = 0; i < 10; i++) begin
      do_wr(TAP_BASE + 12'(4 * i), 32'(i), en);
      wcnt += int'(en);
    end
    @(negedge axis_clk);
    chk("loaded_before_last", taps_loaded, 0);
    tick();
    do_wr(TAP_BASE + 12'd40, 32'd10, en);
    wcnt += int'(en);
    @(negedge axis_clk);
    chk("loaded_after_last", taps_loaded, 1);
    chk("write_count", wcnt, 11);
    tick();

    // Read tap 1 with ready low; engine fetches tap 5 in the meantime
    cfg_rd_req = 1'b1; cfg_rd_addr = TAP_BASE + 12'h004; cfg_rd_ready = 1'b0;
    wait_rd_gnt();
    eng_req = 1'b1; eng_idx = 4'd5;
    @(negedge axis_clk);
    chk("eng_gnt_in_rd_wait", eng_gnt, 1);
    tick();
    eng_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge axis_clk);
      if (i == 0) begin
        chk("eng_data_idx5", eng_data, 32'd5);
        chk("eng_valid_idx5", eng_valid, 1);
      end
      if (cfg_rd_valid && cfg_rd_data == 32'd1) cnt++;
      tick();
    end
    chk("rd_hold_cycles", cnt, 3);
    cfg_rd_ready = 1'b1;
    @(negedge axis_clk);
    chk("rd_valid_at_handshake", cfg_rd_valid, 1);
    tick();
    cfg_rd_ready = 1'b0;
    @(negedge axis_clk);
    chk("rd_valid_after_handshake", cfg_rd_valid, 0);
    tick();

    // Write stalls during a run and goes through the cycle ap_busy falls
    ap_busy = 1'b1; eng_req = 1'b1; eng_idx = 4'd2;
    cfg_wr_req = 1'b1; cfg_wr_addr = TAP_BASE; cfg_wr_data = 32'h100;
    wcnt = 0; ecnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge axis_clk);
      wcnt += int'(cfg_wr_gnt); ecnt += int'(eng_gnt);
      tick();
    end
    chk("busy_wr_grants", wcnt, 0);
    chk("busy_eng_grants", ecnt, 6);
    ap_busy = 1'b0;
    @(negedge axis_clk);
    chk("wr_gnt_on_busy_fall", cfg_wr_gnt, 1);
    chk("eng_gnt_on_busy_fall", eng_gnt, 0);
    tick();
    cfg_wr_req = 1'b0;
    @(negedge axis_clk);
    chk("eng_gnt_after_wr", eng_gnt, 1);
    tick();
    eng_req = 1'b0;

    // Config read vs engine during a run
    ap_busy = 1'b1; eng_req = 1'b1; eng_idx = 4'd3;
    cfg_rd_req = 1'b1; cfg_rd_addr = TAP_BASE + 12'h008;
    first = 0; ecnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge axis_clk);
      if (cfg_rd_gnt && first == 0) first = i;
      ecnt += int'(eng_gnt);
      tick();
      if (first != 0) cfg_rd_req = 1'b0;
    end
`ifdef FIR_TAP_STARVE_GUARD_EN
    chk("starve_first_rd_cycle", first, STARVE_MAX + 1);
    chk("starve_eng_grants", ecnt, 19);
`else
    chk("strict_first_rd_cycle", first, 0);
    chk("strict_eng_grants", ecnt, 20);
`endif
    ap_busy = 1'b0;
    @(negedge axis_clk);
    if (!GUARD) chk("rd_beats_eng_idle", cfg_rd_gnt, 1);
    tick();
    cfg_rd_req = 1'b0; eng_req = 1'b0; cfg_rd_ready = 1'b1;
    wait_rd_valid(d);
    cfg_rd_ready = 1'b0;
    chk("rd_tap2_data", d, 32'd2);

    // Out-of-range tap 12
    do_wr(TAP_BASE + 12'h030, 32'hBAD0_0BAD, en);
    chk("oor_wr_tap_EN", en, 0);
    do_rd(TAP_BASE + 12'h030, d);
    chk("oor_rd_data", d, 32'd0);

    // Reset while holding read data
    cfg_rd_req = 1'b1; cfg_rd_addr = TAP_BASE + 12'h00C; cfg_rd_ready = 1'b0;
    wait_rd_gnt();
    wait_rd_valid(d);
    chk("pre_rst_rd_data", d, 32'd3);
    axis_rst = 1'b1;
    tick();
    axis_rst = 1'b0;
    @(negedge axis_clk);
    chk("rst_hold_rd_valid", cfg_rd_valid, 0);
    chk("rst_hold_taps_loaded", taps_loaded, 0);
    chk("rst_hold_fsm_idle", dut.state == ST_IDLE, 1);
    tick();
    do_rd(TAP_BASE + 12'h004, d);
    chk("post_rst_rd_data", d, 32'd1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
